// File: rtl/rr_arb8_pkg.sv
// Shared constants, FSM encoding and index helper for the 8-way round-robin arbiter.
package rr_arb8_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Requester indices live on a ring of N_REQ; a 3-bit add wraps 7 -> 0 for free.
  function automatic logic [ID_W-1:0] id_next(input logic [ID_W-1:0] id);
    return id + 3'd1;
  endfunction

endpackage

// File: rtl/Or8Way.sv
// Eight-input OR gate: out is high when any input bit is high.
module Or8Way (
  input  logic [7:0] in,
  output logic       out
);

  assign out = |in;

endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest set bit,
// rotate the winner back. An optional index can be excluded from the search.
module rr_pick8
  import rr_arb8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             excl_en,
  input  logic [ID_W-1:0]  excl_id,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  pick_id,
  output logic             pick_valid
);

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  rot_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign cand[gi] = req[gi] & ~(excl_en && (excl_id == ID_W'(gi)));
      assign rot[gi]  = cand[ID_W'(gi) + ptr];
    end
  endgenerate

  always_comb begin
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rot_idx = ID_W'(i);
    end
  end

  assign pick_valid = |cand;
  assign pick_id    = rot_idx + ptr;
  assign pick       = pick_valid ? (N_REQ'(1) << pick_id) : '0;

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with registered one-hot grant and optional
// per-tenure hold limit (HOLD_MAX cycles while others wait; 0 = unlimited).
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int HOLD_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       any_req
);

  localparam int HC_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = (HOLD_MAX == 0) ? '0 : HC_W'(HOLD_MAX - 1);

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [HC_W-1:0]  hold_cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_valid_q;

  logic [N_REQ-1:0] pick;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             timeout;

  Or8Way u_any (
    .in  (req),
    .out (any_req)
  );

  // While granted, the current owner is excluded so a release or timeout always
  // hands over to someone else; with the owner's bit low this changes nothing.
  rr_pick8 u_pick (
    .req        (req),
    .ptr        (ptr_q),
    .excl_en    (state_q == ST_GRANT),
    .excl_id    (gnt_id_q),
    .pick       (pick),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign timeout = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            state_q     <= ST_GRANT;
            gnt_q       <= pick;
            gnt_id_q    <= pick_id;
            gnt_valid_q <= 1'b1;
            ptr_q       <= id_next(pick_id);
            hold_cnt_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (!req[gnt_id_q] || timeout) begin
            if (pick_valid) begin
              gnt_q       <= pick;
              gnt_id_q    <= pick_id;
              ptr_q       <= id_next(pick_id);
              hold_cnt_q  <= '0;
            end else if (!req[gnt_id_q]) begin
              state_q     <= ST_IDLE;
              gnt_q       <= '0;
              gnt_valid_q <= 1'b0;
            end else begin
              // Timed out with nobody waiting: keep the grant, start a fresh window.
              hold_cnt_q  <= '0;
            end
          end else if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb8.sv
// Randomised plus directed bench for rr_arb8: two instances (unlimited hold and
// HOLD_MAX=4) share stimulus and are each compared with a behavioural model.
module tb_rr_arb8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt0, gnt4;
  logic [2:0] id0, id4;
  logic       v0, v4, any0, any4;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model state per instance: index 0 -> HOLD_MAX=0, index 1 -> HOLD_MAX=4.
  int hmax    [2] = '{0, 4};
  int m_owner [2];
  int m_ptr   [2];
  int m_held  [2];
  int m_last  [2];

  always #5 clk = ~clk;

  rr_arb8 #(.HOLD_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0), .any_req(any0)
  );

  rr_arb8 #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4), .any_req(any4)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h (cyc %0d, t=%0t)", tag, got, exp, cyc, $time);
  endtask

  function automatic int search(input logic [7:0] bits, input int from);
    for (int k = 0; k < 8; k++) begin
      if (bits[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
      m_last[d]  = 0;
    end
  endtask

  task automatic model_grant(input int d, input int w);
    m_owner[d] = w;
    m_ptr[d]   = (w + 1) % 8;
    m_held[d]  = 1;
    m_last[d]  = w;
  endtask

  // m_held counts cycles the current grant has been visible, 1 right after a grant.
  task automatic model_step(input int d, input logic [7:0] r);
    int g;
    logic [7:0] others;
    if (m_owner[d] < 0) begin
      if (r != 8'h00) model_grant(d, search(r, m_ptr[d]));
    end else begin
      g = m_owner[d];
      others = r & ~(8'h01 << g);
      if (!r[g]) begin
        if (others != 8'h00) model_grant(d, search(others, m_ptr[d]));
        else m_owner[d] = -1;
      end else if (hmax[d] != 0 && m_held[d] >= hmax[d]) begin
        if (others != 8'h00) model_grant(d, search(others, m_ptr[d]));
        else m_held[d] = 1;
      end else begin
        m_held[d]++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eg [2];
    for (int d = 0; d < 2; d++) eg[d] = (m_owner[d] >= 0) ? 8'(1 << m_owner[d]) : 8'h00;
    check("gnt_h0",   gnt0,       eg[0]);
    check("valid_h0", {7'b0, v0}, {7'b0, m_owner[0] >= 0});
    check("id_h0",    {5'b0, id0}, 8'(m_last[0]));
    check("gnt_h4",   gnt4,       eg[1]);
    check("valid_h4", {7'b0, v4}, {7'b0, m_owner[1] >= 0});
    check("id_h4",    {5'b0, id4}, 8'(m_last[1]));
  endtask

  // Starts and ends at a negedge: drive req, step through one rising edge, compare.
  task automatic cycle(input logic [7:0] r);
    req = r;
    #1;
    check("any_req", {7'b0, any0 & any4}, {7'b0, r != 8'h00});
    @(posedge clk);
    model_step(0, r);
    model_step(1, r);
    @(negedge clk);
    cyc++;
    $display("cyc %0d req=%02h gnt_h0=%02h id_h0=%0d gnt_h4=%02h id_h4=%0d", cyc, r, gnt0, id0, gnt4, id4);
    check_outputs();
  endtask

  task automatic expect_cleared(input string tag);
    check({tag, "_gnt_h0"}, gnt0, 8'h00);
    check({tag, "_v_h0"}, {7'b0, v0}, 8'h00);
    check({tag, "_gnt_h4"}, gnt4, 8'h00);
    check({tag, "_v_h4"}, {7'b0, v4}, 8'h00);
  endtask

  // Called at a negedge; holds reset across one rising edge.
  task automatic apply_reset(input logic [7:0] r);
    rst_n = 1'b0;
    req = r;
    #1;
    expect_cleared("rst");
    @(negedge clk);
    expect_cleared("rst_hold");
    check("rst_id", {5'b0, id0}, 8'h00);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Called at a negedge; reset pulse that never overlaps a rising edge.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    expect_cleared(tag);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int seq2 [9] = '{0, 2, 7, 0, 2, 7, 0, 2, 7};
    logic [7:0] exp4 [6] = '{8'h08, 8'h08, 8'h08, 8'h20, 8'h20, 8'h20};
    logic [7:0] r;
    logic [7:0] lvl;
    int prev;

    model_reset();
    @(negedge clk);

    // Reset with everyone requesting; first edge after release grants 0.
    apply_reset(8'hFF);
    cycle(8'hFF);
    check("t1_first_gnt", gnt0, 8'h01);
    check("t1_first_id", {5'b0, id0}, 8'h00);

    // Rotation 0 -> 2 -> 7 with each owner releasing for one cycle.
    apply_reset(8'h00);
    prev = -1;
    for (int i = 0; i < 9; i++) begin
      r = 8'h85;
      if (prev >= 0) r[prev] = 1'b0;
      cycle(r);
      check("t2_rot_id", {5'b0, id0}, 8'(seq2[i]));
      check("t2_no_idle", {7'b0, v0}, 8'h01);
      prev = seq2[i];
    end

    // Wrap-around: move ptr to 7, then 7 wins over 0, then 0 after 7 releases.
    apply_reset(8'h00);
    cycle(8'h40);
    cycle(8'h81);
    check("t3_wrap_first", gnt0, 8'h80);
    cycle(8'h81);
    cycle(8'h01);
    check("t3_wrap_second", gnt0, 8'h01);

    // Timeout handover on the HOLD_MAX=4 instance.
    apply_reset(8'h00);
    cycle(8'h08);
    check("t4_grant3", gnt4, 8'h08);
    for (int i = 0; i < 6; i++) begin
      cycle(8'h28);
      check("t4_timeout", gnt4, exp4[i]);
    end

    // Lone requester past the limit keeps its grant without a gap.
    apply_reset(8'h00);
    for (int i = 0; i < 20; i++) begin
      cycle(8'h08);
      check("t5_lone", gnt4, 8'h08);
    end

    // Asynchronous reset in the middle of a tenure.
    apply_reset(8'h00);
    for (int i = 0; i < 3; i++) cycle(8'h20);
    check("t6_pre", gnt0, 8'h20);
    reset_pulse("t6_async");
    cycle(8'h20);
    check("t6_regrant", {5'b0, id0}, 8'h05);
    cycle(8'h21);
    cycle(8'h01);
    check("t6_after", gnt0, 8'h01);

    // Random level-sensitive traffic with occasional mid-cycle resets.
    apply_reset(8'h00);
    lvl = 8'h00;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) lvl[b] = ~lvl[b];
      end
      if ($urandom_range(0, 19) == 0) lvl = 8'hFF;
      if ($urandom_range(0, 149) == 0) reset_pulse("rand_rst");
      cycle(lvl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
Name: rr_arb8

Overview:
Round-robin arbiter that shares one resource (memory port, output bus) among 8 requesters with fair rotation and an optional per-grant hold limit. The existing Or8Way gate produces the any-request term. The registered one-hot grant drives the resource's select/mux. Sits between the requesting units and the shared datapath.

Parameters:
HOLD_MAX, 0, max consecutive cycles one grant may be held while others wait; 0 = unlimited; legal 0..255

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req  input  8  request lines, bit i = requester i; level-sensitive, held high for as long as service is wanted
gnt  output  8  registered one-hot grant; all zero when idle
gnt_id  output  3  index of granted requester; valid only when gnt_valid=1
gnt_valid  output  1  registered; 1 iff gnt is non-zero
any_req  output  1  combinational OR of req[7:0] via Or8Way

Behaviour:
- Reset (async assert, rst_n=0): gnt=8'h00, gnt_id=0, gnt_valid=0, state=IDLE, ptr=0, hold_cnt=0. This applies immediately, including mid-grant. The first edge after release evaluates normally.
- ptr (3 bits): highest-priority index. Search order is ptr, ptr+1, ... mod 8 (7 wraps to 0).
- State IDLE:
  - If any_req=1 at an edge: grant the first set req bit in search order. Go to GRANT, set ptr=winner+1 mod 8, set hold_cnt=0.
  - Latency: req asserted in cycle n gives gnt valid in cycle n+1.
- State GRANT, owner g = gnt_id. Evaluated every edge:
  - a) req[g]=0 (release):
    - If other bits are set, hand over in the same edge to the next winner in search order from ptr. Zero idle cycles, gnt changes directly from one one-hot value to another.
    - Otherwise clear gnt and go to IDLE.
  - b) req[g]=1, HOLD_MAX!=0, hold_cnt==HOLD_MAX-1, and some other req bit set (timeout): force handover to the next winner excluding g.
  - c) req[g]=1, timeout reached, no other requester: keep the grant and reset hold_cnt to 0.
  - d) Otherwise keep the grant. hold_cnt increments, saturating at HOLD_MAX-1; it is not used when HOLD_MAX=0.
- Every new grant sets ptr=winner+1 mod 8 and hold_cnt=0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid equals the OR of gnt.
  - gnt_id equals encode(gnt) when valid; it holds its last value when invalid.
- Simultaneous requests are resolved purely by ptr; there is no fixed priority.
- A requester that drops req and re-raises it in the same cycle as a handover is not re-granted until its turn comes around.
- Width: hold_cnt is max(1, clog2(HOLD_MAX+1)) bits. Index arithmetic is modulo 8.
- Fairness: with all 8 requesting continuously, each requester waits at most 7 tenures.

Decomposition:
- Shared package:
  - N_REQ=8
  - ID_W=3
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1
- Sub-module rr_pick8 (combinational):
  - Inputs: req[7:0], ptr[2:0], excl_en, excl_id[2:0].
  - Outputs: one-hot pick[7:0], pick_id[2:0], pick_valid.
  - Implementation: rotate, priority-encode, rotate back.
  - rr_arb8 is the state/pointer/counter shell around it.
- any_req is an instance of the existing Or8Way.

Test Plan:
1. Reset/idle: hold rst_n=0 with req=8'hFF, then release. Required: gnt=00 and gnt_valid=0 during reset; on the first edge, gnt=8'h01, gnt_id=0.
2. Rotation: HOLD_MAX=0, req=8'b1000_0101, each owner drops req one cycle after being granted and re-raises it the cycle after that. Required grant sequence: 0, 2, 7, 0, 2, ... with no idle cycle between owners.
3. Wrap-around: ptr at 7, req=8'b1000_0001. Required: grant 7 first; after it releases, grant 0.
4. Timeout: HOLD_MAX=4, req[3]=1 held, req[5] raised in the cycle after grant 3. Required: gnt=8'h08 for exactly 4 cycles, then 8'h20.
5. Timeout alone: HOLD_MAX=4, only req[3]=1 for 20 cycles. Required: gnt=8'h08 continuously, no glitch to 0.
6. Async reset mid-grant: gnt=8'h20 held, pulse rst_n low between edges. Required: gnt=00 and gnt_valid=0 immediately, before the next edge. After release with req=8'h20, the regrant to 5 occurs from ptr=0.
